// File: rtl/fa_pkg.sv
// Shared types and constants for the registered full adder.
// The optional FA_CARRY_CNT_EN build adds a carry-event counter to full_adder_reg.
package fa_pkg;
    localparam int FA_RESULT_W = 2;
    localparam int FA_CNT_W    = 8;

    typedef logic [FA_RESULT_W-1:0] fa_result_t;
endpackage

// File: rtl/fa_core.sv
// Gate-level single-bit full adder: two XOR, two AND, one OR.
module fa_core (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    logic p, g, t;

    // p is the propagate term, g generate, t the carry passed through from c_in
    xor u_x0 (p, a, b);
    xor u_x1 (sum, p, c_in);
    and u_a0 (g, a, b);
    and u_a1 (t, p, c_in);
    or  u_o0 (c_out, g, t);
endmodule

// File: rtl/full_adder_reg.sv
// Full adder with internal carry register for bit-serial (LSB-first) addition
// and optional output register. FA_CARRY_CNT_EN adds a saturating carry_cnt output.
module full_adder_reg
    import fa_pkg::*;
#(
    parameter int REG_OUT  = 1,
    parameter int RESULT_W = FA_RESULT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                a,
    input  logic                b,
    input  logic                c_in,
    input  logic                serial_en,
    input  logic                carry_clr,
    output logic                sum,
    output logic                c_out,
    output logic [RESULT_W-1:0] result,
    output logic                out_valid
`ifdef FA_CARRY_CNT_EN
    ,
    output logic [FA_CNT_W-1:0] carry_cnt
`endif
);
    if (RESULT_W != FA_RESULT_W) begin : g_bad_w
        $error("full_adder_reg: RESULT_W must be 2");
    end

    logic carry_q;
    logic cin_eff;
    logic core_sum, core_cout;
    fa_result_t res;

    assign cin_eff = serial_en ? carry_q : c_in;

    fa_core u_core (
        .a     (a),
        .b     (b),
        .c_in  (cin_eff),
        .sum   (core_sum),
        .c_out (core_cout)
    );

    // carry_clr wins over a simultaneous beat; that beat still consumed the old carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            carry_q <= 1'b0;
        else if (carry_clr) carry_q <= 1'b0;
        else if (in_valid)  carry_q <= core_cout;
    end

    if (REG_OUT != 0) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum       <= 1'b0;
                c_out     <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    sum   <= core_sum;
                    c_out <= core_cout;
                end
            end
        end
    end else begin : g_comb
        assign sum       = core_sum;
        assign c_out     = core_cout;
        assign out_valid = in_valid;
    end

    assign res    = {c_out, sum};
    assign result = res;

`ifdef FA_CARRY_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            carry_cnt <= '0;
        else if (carry_clr)
            carry_cnt <= '0;
        else if (in_valid && core_cout && (carry_cnt != {FA_CNT_W{1'b1}}))
            carry_cnt <= carry_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_full_adder_reg.sv
// Self-checking bench for full_adder_reg (REG_OUT = 1): directed scenarios plus
// randomized beats scored against an arithmetic reference model.
module tb_full_adder_reg;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, a, b, c_in, serial_en, carry_clr;
    logic       sum, c_out, out_valid;
    logic [1:0] result;
`ifdef FA_CARRY_CNT_EN
    logic [7:0] carry_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_carry, m_sum, m_cout, m_ov, m_cnt;

    always #5 clk = ~clk;

    full_adder_reg #(.REG_OUT(1), .RESULT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .serial_en (serial_en),
        .carry_clr (carry_clr),
        .sum       (sum),
        .c_out     (c_out),
        .result    (result),
        .out_valid (out_valid)
`ifdef FA_CARRY_CNT_EN
        ,
        .carry_cnt (carry_cnt)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_carry = 0; m_sum = 0; m_cout = 0; m_ov = 0; m_cnt = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".sum"},       int'(sum),       m_sum);
        chk({tag, ".c_out"},     int'(c_out),     m_cout);
        chk({tag, ".result"},    int'(result),    m_cout * 2 + m_sum);
        chk({tag, ".out_valid"}, int'(out_valid), m_ov);
        chk({tag, ".carry_q"},   int'(dut.carry_q), m_carry);
`ifdef FA_CARRY_CNT_EN
        chk({tag, ".carry_cnt"}, int'(carry_cnt), m_cnt);
`endif
    endtask

    // Called just after a negedge: drive, let the posedge sample, check at next negedge.
    task automatic beat(input string tag, input int v, input int va, input int vb,
                        input int vc, input int ser, input int clr);
        int cin, total;
        in_valid  = v[0];
        a         = va[0];
        b         = vb[0];
        c_in      = vc[0];
        serial_en = ser[0];
        carry_clr = clr[0];
        @(posedge clk);
        cin   = ser ? m_carry : vc;
        total = va + vb + cin;
        m_ov  = v;
        if (v != 0) begin
            m_sum  = total % 2;
            m_cout = total / 2;
            if (m_cout == 1 && m_cnt < 255) m_cnt++;
        end
        if (clr != 0) begin
            m_carry = 0;
            m_cnt   = 0;
        end else if (v != 0) begin
            m_carry = total / 2;
        end
        @(negedge clk);
        chk_all(tag);
    endtask

    initial begin
        int exp_tab[8] = '{0, 1, 1, 2, 1, 2, 2, 3};
        int sa[4] = '{0, 1, 1, 0};
        int sb[4] = '{1, 1, 0, 0};
        int ssum[4] = '{1, 0, 0, 1};

        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; c_in = 0; serial_en = 0; carry_clr = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_all("reset");
        rst = 1'b0;

        // exhaustive truth table, external carry-in
        for (int i = 0; i < 8; i++) begin
            beat("tt", 1, (i >> 2) & 1, (i >> 1) & 1, i & 1, 0, 0);
            chk("tt.spec", int'(result), exp_tab[i]);
        end

        // serial 0110 + 0011 = 1001
        beat("clr", 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            beat("ser", 1, sa[i], sb[i], 1, 1, 0);
            chk("ser.sumbit", int'(sum), ssum[i]);
        end
        chk("ser.cout", int'(c_out), 0);

        // serial 1111 + 0001 overflows
        beat("clr2", 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            beat("ovf", 1, 1, (i == 0) ? 1 : 0, 0, 1, 0);
            chk("ovf.sumbit", int'(sum), 0);
        end
        chk("ovf.cout", int'(c_out), 1);

        // hold: toggling inputs while idle must not disturb anything
        for (int i = 0; i < 5; i++)
            beat("hold", 0, i & 1, ~i & 1, i & 1, i & 1, 0);

        // reset mid-word with carry_q = 1
        beat("clr3", 0, 0, 0, 0, 1, 1);
        beat("mw0", 1, 1, 1, 0, 1, 0);
        beat("mw1", 1, 1, 0, 0, 1, 0);
        chk("mw.carry", int'(dut.carry_q), 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        beat("after_rst", 1, 0, 0, 1, 1, 0);
        chk("after_rst.spec", int'(result), 0);

`ifdef FA_CARRY_CNT_EN
        beat("cnt_clr", 0, 0, 0, 0, 0, 1);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 8; i++)
                beat("cnt_tt", 1, (i >> 2) & 1, (i >> 1) & 1, i & 1, 0, 0);
        chk("cnt.eight", int'(carry_cnt), 8);
        beat("cnt_clr2", 0, 0, 0, 0, 0, 1);
        chk("cnt.zero", int'(carry_cnt), 0);
`endif

        // randomized beats, including clears coinciding with valid beats
        for (int i = 0; i < 400; i++) begin
            beat("rnd", ($urandom_range(0, 3) != 0) ? 1 : 0,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 9) == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
